// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the MEM-stage load/store unit: FSM state encoding,
// RV32I load/store funct3 codes and the natural-alignment test.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halves need addr[0]=0; words (and unknown sizes) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = addr_lo[0];
            default:     mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte enables / lane replication and load
// byte/half extraction with sign or zero extension.
module lsu_lane_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] load_out
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store byte enables and lane replication; reads always use the full word.
    always_comb begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_out = {4{wdata_in[7:0]}};
                end
                F3_H: begin
                    be        = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_out = {2{wdata_in[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_out = wdata_in;
                end
            endcase
        end else begin
            be        = 4'b1111;
            wdata_out = wdata_in;
        end
    end

    // Lane selection; addr_lo[0] is ignored for halves (forced alignment).
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata_in[7:0];
            2'b01:   byte_s = rdata_in[15:8];
            2'b10:   byte_s = rdata_in[23:16];
            2'b11:   byte_s = rdata_in[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata_in[31:16];
        end else begin
            half_s = rdata_in[15:0];
        end
    end

    // Extension per load type; unknown funct3 returns the whole word.
    always_comb begin
        load_out = rdata_in;
        case (funct3)
            F3_B:    load_out = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_out = {24'h000000, byte_s};
            F3_H:    load_out = {{16{half_s[15]}}, half_s};
            F3_HU:   load_out = {16'h0000, half_s};
            default: load_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: variable-latency dmem req/ack handshake with stall,
// optional ack timeout and optional misalignment trap (macro LSU_MISALIGN_TRAP_EN).
module mem_lsu
    import pipeline_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic        hold_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_m,
    output logic        stall_mem,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_m,
`endif
    output logic        bus_err_m
);

    localparam bit               TMO_EN    = (ACK_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

    lsu_state_t        state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              bus_err_q, bus_err_d;

    logic              access_s;
    logic              misalign_s;
    logic              issue_s;
    logic              req_s;
    logic              stall_s;
    logic              req_out_s;
    logic [31:0]       load_s;
    logic              err_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       fmt_load_s;
    logic [31:0]       capture_s;

    assign access_s = valid_m & (mem_read_m | mem_write_m);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(funct3_m, addr_m[1:0]);
    assign misalign_m = (state_q == IDLE) & access_s & misalign_s;
`else
    assign misalign_s = 1'b0;
`endif

    assign issue_s = access_s & ~misalign_s;

    lsu_lane_align u_lane (
        .funct3    (funct3_m),
        .addr_lo   (addr_m[1:0]),
        .is_store  (mem_write_m),
        .wdata_in  (wdata_m),
        .rdata_in  (dmem_rdata),
        .be        (be_s),
        .wdata_out (wdata_s),
        .load_out  (fmt_load_s)
    );

    // Stores retire with a zero result; only loads carry memory data forward.
    assign capture_s = mem_read_m ? fmt_load_s : 32'h0000_0000;

    // Next-state, counter, result capture and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        bus_err_d = bus_err_q;
        req_s     = 1'b0;
        stall_s   = 1'b0;
        load_s    = 32'h0000_0000;
        err_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    req_s     = 1'b1;
                    stall_s   = 1'b1;
                    cnt_d     = {TMO_W{1'b0}};
                    bus_err_d = 1'b0;
                    if (dmem_ack) begin
                        result_d = capture_s;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                // An abort drops req in the same cycle, so a late ack is ignored.
                if (TMO_EN && (cnt_q == TMO_LIMIT)) begin
                    result_d  = 32'h0000_0000;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    req_s = 1'b1;
                    cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
                    if (dmem_ack) begin
                        result_d = capture_s;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            DONE: begin
                load_s = result_q;
                err_s  = bus_err_q;
                if (hold_m) begin
                    state_d = DONE;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = {TMO_W{1'b0}};
                    bus_err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {TMO_W{1'b0}};
            result_q  <= 32'h0000_0000;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Reset forces the bus quiet at once, even while a request is being decoded.
    assign req_out_s   = req_s & ~reset;
    assign dmem_req    = req_out_s;
    assign dmem_we     = req_out_s & mem_write_m;
    assign dmem_be     = req_out_s ? be_s : 4'b0000;
    assign dmem_addr   = req_out_s ? {addr_m[31:2], 2'b00} : 32'h0000_0000;
    assign dmem_wdata  = (req_out_s & mem_write_m) ? wdata_s : 32'h0000_0000;
    assign stall_mem   = stall_s & ~reset;
    assign load_data_m = load_s;
    assign bus_err_m   = err_s;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver pushes expected requests/retirements,
// a monitor pops and compares them as the DUT presents them.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, mem_read_m, mem_write_m, hold_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data_m;
    logic        stall_mem, bus_err_m;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_m;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] load;
        logic        err;
        int          stall;
        int          reqs;
    } ret_t;

    req_t req_q[$];
    ret_t ret_q[$];

    mem_lsu #(.ACK_TIMEOUT(4), .TMO_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_m     (valid_m),
        .mem_read_m  (mem_read_m),
        .mem_write_m (mem_write_m),
        .funct3_m    (funct3_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .hold_m      (hold_m),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .load_data_m (load_data_m),
        .stall_mem   (stall_mem),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_m  (misalign_m),
`endif
        .bus_err_m   (bus_err_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after the driving edge, ahead of the next posedge.
    initial begin : monitor
        int   stall_cnt;
        int   req_cnt;
        bit   req_seen;
        req_t r;
        ret_t t;
        stall_cnt = 0;
        req_cnt   = 0;
        req_seen  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stall_cnt = 0;
                req_cnt   = 0;
                req_seen  = 1'b0;
            end else begin
                if (stall_mem) stall_cnt++;
                if (dmem_req) req_cnt++;
                if (dmem_req && !req_seen) begin
                    req_seen = 1'b1;
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_we",    32'(dmem_we),  32'(r.we));
                        chk("req_be",    32'(dmem_be),  32'(r.be));
                        chk("req_addr",  dmem_addr,     r.addr);
                        chk("req_wdata", dmem_wdata,    r.wdata);
                    end
                end
                if (valid_m && (mem_read_m || mem_write_m) && !stall_mem) begin
                    if (ret_q.size() == 0) begin
                        chk("unexpected_retire", 32'd1, 32'd0);
                    end else if (hold_m) begin
                        chk("hold_load", load_data_m,     ret_q[0].load);
                        chk("hold_req",  32'(dmem_req),   32'd0);
                    end else begin
                        t = ret_q.pop_front();
                        chk("ret_load",  load_data_m,     t.load);
                        chk("ret_err",   32'(bus_err_m),  32'(t.err));
                        chk("ret_stall", 32'(stall_cnt),  32'(t.stall));
                        chk("ret_reqs",  32'(req_cnt),    32'(t.reqs));
                        stall_cnt = 0;
                        req_cnt   = 0;
                        req_seen  = 1'b0;
                    end
                end
            end
        end
    end

    // One memory access; ack_dly counts cycles from the request cycle (-1 = never).
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                          input int ack_dly, input int hold_n,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_load, input logic e_err,
                          input int e_stall, input int e_reqs);
        req_t r;
        ret_t t;
        int   k;
        int   held;
        bit   done;
        r.we = wr; r.be = e_be; r.addr = {addr[31:2], 2'b00}; r.wdata = e_wdata;
        req_q.push_back(r);
        t.load = e_load; t.err = e_err; t.stall = e_stall; t.reqs = e_reqs;
        ret_q.push_back(t);
        @(negedge clk);
        valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
        addr_m = addr; wdata_m = wd; dmem_rdata = rdat; hold_m = 1'b0;
        dmem_ack = (ack_dly == 0);
        k = 0; held = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            k++;
            if (!stall_mem) begin
                dmem_ack = 1'b0;
                if (held < hold_n) begin
                    hold_m = 1'b1;
                    held++;
                end else begin
                    hold_m = 1'b0;
                    done   = 1'b1;
                end
            end else begin
                dmem_ack = (k == ack_dly);
            end
        end
        if (!done) chk("op_no_completion", 32'd0, 32'd1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; hold_m = 1'b0;
        dmem_ack = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1; valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        funct3_m = 3'b000; addr_m = 32'h0; wdata_m = 32'h0; hold_m = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   32'(dmem_req),  32'd0);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        chk("rst_load",  load_data_m,    32'd0);
        chk("rst_err",   32'(bus_err_m), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //     rd    wr    f3      addr          wdata          rdata          ack hold be       wdata exp      load exp       err  stl req
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344, 32'h0,          0, 0, 4'b1111, 32'h1122_3344, 32'h0,          1'b0, 1, 1);
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 32'h0,          3, 0, 4'b1000, 32'hABAB_ABAB, 32'h0,          1'b0, 4, 4);
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,          32'h0080_FF00, 1, 0, 4'b1111, 32'h0,          32'hFFFF_FF80, 1'b0, 2, 2);
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,          32'h0080_FF00, 0, 0, 4'b1111, 32'h0,          32'h0000_0080, 1'b0, 1, 1);
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,          32'h0080_FF00, 2, 0, 4'b1111, 32'h0,          32'h0000_0080, 1'b0, 3, 3);
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,          32'h0080_FF00, 0, 0, 4'b1111, 32'h0,          32'hFFFF_FF00, 1'b0, 1, 1);
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,          32'h0080_FF00, 0, 0, 4'b1111, 32'h0,          32'hFFFF_FFFF, 1'b0, 1, 1);
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_CAFE, 32'h0,          0, 0, 4'b1100, 32'hCAFE_CAFE, 32'h0,          1'b0, 1, 1);
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'h0000_005A, 32'h0,          0, 0, 4'b0001, 32'h5A5A_5A5A, 32'h0,          1'b0, 1, 1);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0,          32'hDEAD_BEEF, 0, 2, 4'b1111, 32'h0,          32'hDEAD_BEEF, 1'b0, 1, 1);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,          32'h7777_7777, -1, 0, 4'b1111, 32'h0,         32'h0,          1'b1, 6, 5);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0,          32'hCAFE_F00D, 1, 0, 4'b1111, 32'h0,          32'hCAFE_F00D, 1'b0, 2, 2);
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_0308, 32'h0,          32'h0102_0304, 0, 0, 4'b1111, 32'h0,          32'h0102_0304, 1'b0, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        begin
            ret_t t;
            t.load = 32'h0; t.err = 1'b0; t.stall = 0; t.reqs = 0;
            ret_q.push_back(t);
            @(negedge clk);
            valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010;
            addr_m = 32'h0000_0101; dmem_ack = 1'b0; hold_m = 1'b0;
            #1;
            chk("mis_flag",  32'(misalign_m), 32'd1);
            chk("mis_req",   32'(dmem_req),   32'd0);
            chk("mis_stall", 32'(stall_mem),  32'd0);
            chk("mis_load",  load_data_m,     32'd0);
        end
`else
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,          32'h1234_8765, 0, 0, 4'b1111, 32'h0,          32'hFFFF_8765, 1'b0, 1, 1);
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0103, 32'h89AB_CDEF, 32'h0,          0, 0, 4'b1111, 32'h89AB_CDEF, 32'h0,          1'b0, 1, 1);
`endif

        // Reset while the unit waits in BUSY.
        begin
            req_t r;
            r.we = 1'b0; r.be = 4'b1111; r.addr = 32'h0000_0400; r.wdata = 32'h0;
            req_q.push_back(r);
        end
        @(negedge clk);
        valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010;
        addr_m = 32'h0000_0400; dmem_ack = 1'b0; hold_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy_req",   32'(dmem_req),  32'd0);
        chk("rst_busy_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        valid_m = 1'b0; mem_read_m = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_stall", 32'(stall_mem), 32'd0);
        chk("post_rst_req",   32'(dmem_req),  32'd0);

        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 0, 0, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 1, 1);
        go_idle();
        repeat (3) @(negedge clk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("ret_q_drained", 32'(ret_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
